// File: rtl/apb_master_n.sv
// -----------------------------------------------------------------------------
// apb_master_n
//
// Parametrised APB bridge between the RV32I core's simple request bus and
// NUM_SLAVES APB peripherals laid out in consecutive 2**SLOT_BITS-byte slots
// starting at BASE_ADDR.
//
// A request is a one-cycle `transfer` strobe carrying write/addr/wdata. Mapped
// addresses run a normal APB SETUP/ACCESS sequence. Unmapped addresses get a
// one-cycle error completion and never select a slave. Completion is a
// one-cycle `ready` pulse. `rdata` and `err` are valid only during that pulse.
//
// Optional feature (macro APB_TIMEOUT_EN): abort an ACCESS phase that has seen
// TIMEOUT_CYCLES cycles without PREADY. The abort completes with err=1 and
// rdata=32'hDEAD_BEEF. Without the macro, ACCESS waits for PREADY indefinitely.
//
// Ports:
//   PCLK, PRESET          clock, asynchronous active-low reset
//   transfer/write/addr/wdata   CPU request (sampled only in IDLE)
//   rdata/ready/err       CPU completion
//   PADDR/PWRITE/PWDATA   APB request, registered, stable for the transfer
//   PENABLE/PSEL          APB phase control, PSEL one-hot or zero
//   PRDATA/PREADY         per-slave response, slave i at PRDATA[32*i +: 32]
// -----------------------------------------------------------------------------
module apb_master_n #(
    parameter int          NUM_SLAVES     = 5,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          SLOT_BITS      = 12,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      transfer,
    input  logic                      write,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      ready,
    output logic                      err,
    output logic [31:0]               PADDR,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [31:0]               PWDATA,
    output logic [NUM_SLAVES-1:0]     PSEL,
    input  logic [32*NUM_SLAVES-1:0]  PRDATA,
    input  logic [NUM_SLAVES-1:0]     PREADY
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Reject configurations the decoder cannot represent.
    generate
        if ((NUM_SLAVES < 1) || (NUM_SLAVES > 16)) begin : g_bad_num
            $error("apb_master_n: NUM_SLAVES must be 1..16");
        end
        if ((SLOT_BITS < 1) || (SLOT_BITS > 31)) begin : g_bad_slot
            $error("apb_master_n: SLOT_BITS must be 1..31");
        end
        if ((BASE_ADDR & ((32'd1 << SLOT_BITS) - 32'd1)) != 32'd0) begin : g_bad_base
            $error("apb_master_n: BASE_ADDR must be slot aligned");
        end
        if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_tmo
            $error("apb_master_n: TIMEOUT_CYCLES must be 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [IDX_W-1:0]   idx_r;

    logic [31:0]        off_s;
    logic [31:0]        slot_s;
    logic               hit_s;
    logic [IDX_W-1:0]   idx_s;
    logic               pready_sel_s;
    logic [31:0]        prdata_sel_s;
    logic               sel_act_s;

`ifdef APB_TIMEOUT_EN
    logic [15:0]        tmo_cnt_r;
    logic               tmo_hit_s;
`endif

    // Address decode: slot index relative to BASE_ADDR and in-range check.
    always_comb begin
        off_s  = addr - BASE_ADDR;
        slot_s = off_s >> SLOT_BITS;
        hit_s  = (addr >= BASE_ADDR) && (slot_s < 32'(NUM_SLAVES));
        idx_s  = slot_s[IDX_W-1:0];
    end

    // Response mux: only the latched slave's PREADY/PRDATA are looked at.
    always_comb begin
        pready_sel_s = 1'b0;
        prdata_sel_s = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                pready_sel_s = PREADY[i];
                prdata_sel_s = PRDATA[32*i +: 32];
            end else begin
                pready_sel_s = pready_sel_s;
                prdata_sel_s = prdata_sel_s;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    assign tmo_hit_s = (tmo_cnt_r == 16'(TIMEOUT_CYCLES));

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without PREADY.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ST_SETUP) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_ACCESS) && !pready_sel_s && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and completion outputs; completion is combinational so ready
    // lands in the same cycle PREADY is seen.
    always_comb begin
        state_nx_s = state_r;
        ready      = 1'b0;
        err        = 1'b0;
        rdata      = 32'd0;
        sel_act_s  = 1'b0;
        PENABLE    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (transfer) begin
                    if (hit_s) begin
                        state_nx_s = ST_SETUP;
                    end else begin
                        state_nx_s = ST_ERROR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                sel_act_s  = 1'b1;
                state_nx_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                sel_act_s = 1'b1;
                PENABLE   = 1'b1;
                // A PREADY in the timeout cycle still counts as a normal finish.
                if (pready_sel_s) begin
                    ready      = 1'b1;
                    rdata      = PWRITE ? 32'd0 : prdata_sel_s;
                    state_nx_s = ST_IDLE;
`ifdef APB_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    ready      = 1'b1;
                    err        = 1'b1;
                    rdata      = 32'hDEAD_BEEF;
                    state_nx_s = ST_IDLE;
`endif
                end else begin
                    state_nx_s = ST_ACCESS;
                end
            end
            ST_ERROR: begin
                ready      = 1'b1;
                err        = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // One-hot slave select from the latched index; zero outside SETUP/ACCESS.
    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_act_s && (idx_r == IDX_W'(i))) begin
                PSEL[i] = 1'b1;
            end else begin
                PSEL[i] = 1'b0;
            end
        end
    end

    // Request capture: latched only when a mapped request is accepted in IDLE,
    // so the APB request stays stable through wait states.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            PADDR  <= 32'd0;
            PWDATA <= 32'd0;
            PWRITE <= 1'b0;
            idx_r  <= '0;
        end else if ((state_r == ST_IDLE) && transfer && hit_s) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            idx_r  <= idx_s;
        end else begin
            PADDR  <= PADDR;
            PWDATA <= PWDATA;
            PWRITE <= PWRITE;
            idx_r  <= idx_r;
        end
    end

endmodule

// File: doc/apb_master_n.md
Name: apb_master_n

Overview:
- Parametrised APB bridge between the RV32I core's simple bus (transfer/ready/write/addr/wdata/rdata) and NUM_SLAVES APB peripherals.
- Next generation of the fixed five-slave APB master:
  - slave count and address map come from parameters;
  - adds unmapped-address error response;
  - adds an optional PREADY timeout.
- Sits between CPU_RV32I and the RAM, GPO, GPI, GPIO and FND peripherals inside MCU.

Parameters:
- NUM_SLAVES, 5, number of APB slave slots (1..16).
- BASE_ADDR, 32'h1000_0000, start of the peripheral region; low SLOT_BITS must be zero.
- SLOT_BITS, 12, log2 of bytes per slave slot (0x1000-byte slots).
- TIMEOUT_CYCLES, 255, ACCESS cycles without PREADY before abort (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  asynchronous, active-low reset.
- transfer  in  1  one-cycle request strobe from CPU.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  32  byte address; sampled with transfer.
- wdata  in  32  write data; sampled with transfer.
- rdata  out  32  read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid while ready=1.
- PADDR  out  32  APB address (registered copy of addr).
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  32*NUM_SLAVES  slave read data; slave i occupies bits [32*i+31:32*i].
- PREADY  in  NUM_SLAVES  slave ready, one bit per slave.

Behaviour:
- Reset (PRESET=0, asynchronous):
  - state=IDLE;
  - PADDR, PWDATA, PWRITE, PENABLE, PSEL, ready, err, rdata all 0;
  - timeout counter 0.
  - Reset mid-transfer abandons the transfer with no ready pulse.
- Decode (combinational on addr):
  - idx = (addr - BASE_ADDR) >> SLOT_BITS.
  - Hit when addr >= BASE_ADDR and idx < NUM_SLAVES.
  - Address bits below SLOT_BITS are passed through unchanged on PADDR.
- FSM states: IDLE, SETUP, ACCESS, ERROR.
- IDLE:
  - transfer=1 and hit: latch addr, wdata, write and the slave index; go to SETUP.
  - transfer=1 and miss: go to ERROR.
  - transfer is sampled only in IDLE and ignored in every other state.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0; next state ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - When PREADY[idx]=1, in the same cycle (combinational):
    - ready=1, err=0;
    - rdata = PRDATA slice idx on reads, 0 on writes;
    - next state IDLE.
  - Otherwise stay in ACCESS; PADDR, PWDATA and PWRITE are held stable.
- ERROR (1 cycle):
  - ready=1, err=1, rdata=0;
  - no PSEL asserted;
  - next state IDLE.
- Outside the completion cycle, ready=0, err=0 and rdata=0.
- PREADY bits of unselected slaves are ignored.
- Minimum latency: transfer in cycle 0 → SETUP in cycle 1 → ready in cycle 2 with a zero-wait slave. Each wait state adds 1 cycle.
- Back-to-back: a transfer asserted in the ready cycle is ignored. The CPU issues its next transfer no earlier than the cycle after ready, which gives at least 1 IDLE cycle between transfers.
- PSEL is always one-hot or zero; never more than one bit set.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter reaches TIMEOUT_CYCLES:
    - drop PSEL and PENABLE next cycle;
    - pulse ready=1, err=1, rdata=32'hDEAD_BEEF;
    - return to IDLE.
  - A PREADY arriving in the same cycle as the timeout wins: normal completion, err=0.
- Undefined: no counter; ACCESS waits indefinitely for PREADY; err is driven only by unmapped addresses.

Test Plan:
- Read, zero-wait:
  - Stimulus: NUM_SLAVES=5; slave 1 returns PRDATA=32'h0000_00A5 with PREADY tied 1; transfer read at addr 32'h1000_1000.
  - Response: PSEL=5'b00010 in cycles 1–2; PENABLE=1 in cycle 2; ready=1, rdata=32'hA5, err=0 in cycle 2.
- Write with waits:
  - Stimulus: write 32'h1234_5678 to 32'h1000_3004; slave 3 holds PREADY=0 for 3 cycles.
  - Response: PADDR=32'h1000_3004 and PWDATA=32'h1234_5678 stable through ACCESS; ready in cycle 5; rdata=0.
- Unmapped address:
  - Stimulus: transfer at 32'h1000_5000 (idx 5), and again at 32'h0FFF_FFFC.
  - Response: ready=1, err=1, rdata=0 in cycle 1; PSEL=0 throughout.
- Reset mid-operation:
  - Stimulus: assert PRESET=0 during ACCESS with PREADY=0.
  - Response: PSEL, PENABLE and ready go to 0 immediately (asynchronously); after release, a new read to slave 0 completes normally.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: slave 2 never raises PREADY.
  - Response: ready=1, err=1, rdata=32'hDEAD_BEEF after 4 ACCESS cycles; FSM back in IDLE.
- Ignored strobe: transfer held high during SETUP and ACCESS → exactly one APB transaction per IDLE-sampled strobe.
